// File: rtl/spi_reg_slave.sv
// SPI responder with an addressable register file: 16-bit frames (command byte, then data byte),
// writes commit at bit 16, reads shift the addressed register out MSB first.
module spi_reg_slave #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              ss,
  input  logic              in,
  output logic              out,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              busy,
  output logic              wr_done,
  output logic              rd_done,
  output logic [ADDR_W-1:0] rx_addr
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StCmd, StData, StWait} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [6:0]         shift_q, shift_d;
  logic [7:0]         tx_q, tx_d;
  logic               rw_q, rw_d;
  logic               out_q, out_d;
  logic               wr_done_q, wr_done_d;
  logic               rd_done_q, rd_done_d;
  logic [ADDR_W-1:0]  rx_addr_q, rx_addr_d;
  logic [DATA_W-1:0]  mem_q [Depth];
  logic               mem_we;
  logic [DATA_W-1:0]  mem_wdata;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [DATA_W-1:0]  rd_word;

  // Address field of the command byte completed by the current edge.
  assign cmd_addr = ADDR_W'({shift_q, in});
  assign rd_word  = mem_q[cmd_addr];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    rx_addr_d = rx_addr_q;
    out_d     = 1'b0;
    wr_done_d = 1'b0;
    rd_done_d = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = {shift_q, in};
    unique case (state_q)
      StIdle: begin
        if (!ss) begin
          shift_d = {shift_q[5:0], in};
          cnt_d   = 4'd1;
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (ss) begin
          cnt_d   = 4'd0;
          state_d = StIdle;
        end else begin
          shift_d = {shift_q[5:0], in};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            rw_d      = shift_q[6];
            rx_addr_d = cmd_addr;
            if (shift_q[6]) begin
              // MSB goes out now; tx keeps the remaining bits left-aligned.
              out_d = rd_word[7];
              tx_d  = {rd_word[6:0], 1'b0};
            end
            state_d = StData;
          end
        end
      end
      StData: begin
        if (ss) begin
          cnt_d   = 4'd0;
          state_d = StIdle;
        end else begin
          shift_d = {shift_q[5:0], in};
          cnt_d   = cnt_q + 4'd1;
          if (rw_q) begin
            out_d = tx_q[7];
            tx_d  = {tx_q[6:0], 1'b0};
          end
          if (cnt_q == 4'd15) begin
            out_d = 1'b0;
            cnt_d = 4'd0;
            if (rw_q) begin
              rd_done_d = 1'b1;
            end else begin
              mem_we    = 1'b1;
              wr_done_d = 1'b1;
            end
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (ss) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      shift_q   <= 7'd0;
      tx_q      <= 8'd0;
      rw_q      <= 1'b0;
      out_q     <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      rx_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      rw_q      <= rw_d;
      out_q     <= out_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
      rx_addr_q <= rx_addr_d;
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[rx_addr_q] <= mem_wdata;
    end
  end

  assign out      = out_q;
  assign busy     = (state_q != StIdle);
  assign wr_done  = wr_done_q;
  assign rd_done  = rd_done_q;
  assign rx_addr  = rx_addr_q;
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: tb/tb_spi_reg_slave.sv
// Scoreboard bench for spi_reg_slave: stimulus pushes expected completions, a monitor pops them
// on each wr_done/rd_done pulse and checks address, serial read data and quiet output.
module tb_spi_reg_slave;

  logic       sclk;
  logic       rst;
  logic       ss;
  logic       in;
  logic       out;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;
  logic       busy;
  logic       wr_done;
  logic       rd_done;
  logic [2:0] rx_addr;

  spi_reg_slave #(
    .ADDR_W (3),
    .DATA_W (8)
  ) dut (
    .sclk     (sclk),
    .rst      (rst),
    .ss       (ss),
    .in       (in),
    .out      (out),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .busy     (busy),
    .wr_done  (wr_done),
    .rd_done  (rd_done),
    .rx_addr  (rx_addr)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  typedef struct {
    bit       is_read;
    bit [2:0] addr;
    bit [7:0] data;
  } exp_t;

  exp_t     expq[$];
  bit [7:0] model [8];
  int       n_tests;
  int       n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Serial samples of out, one per cycle; the 8 samples before rd_done are the read byte.
  task automatic monitor();
    bit [7:0] hist;
    exp_t     e;
    hist = 8'h00;
    forever begin
      @(negedge sclk);
      if (wr_done || rd_done) begin
        check("pulses_exclusive", {31'd0, wr_done & rd_done}, 32'd0);
        if (expq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pulse: got wr_done=%0b rd_done=%0b, expected none", wr_done,
                   rd_done);
        end else begin
          e = expq.pop_front();
          check("pulse_kind_rd", {31'd0, rd_done}, {31'd0, e.is_read});
          check("rx_addr", {29'd0, rx_addr}, {29'd0, e.addr});
          if (e.is_read) check("rd_data", {24'd0, hist}, {24'd0, e.data});
          else check("wr_out_quiet", {24'd0, hist}, 32'd0);
          check("out_zero_at_done", {31'd0, out}, 32'd0);
        end
      end
      hist = {hist[6:0], out};
    end
  endtask

  task automatic drive(input logic b, input logic s);
    @(negedge sclk);
    ss = s;
    in = b;
  endtask

  task automatic send_bits(input logic [23:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) drive(bits[i], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1);
  endtask

  task automatic frame(input bit [7:0] cmd, input bit [7:0] data);
    exp_t e;
    e.is_read = cmd[7];
    e.addr    = cmd[2:0];
    if (cmd[7]) begin
      e.data = model[cmd[2:0]];
    end else begin
      e.data = data;
      model[cmd[2:0]] = data;
    end
    expq.push_back(e);
    send_bits({8'h00, cmd, data}, 16);
    idle(1);
  endtask

  task automatic check_dbg(input string name, input bit [2:0] a);
    dbg_addr = a;
    #1;
    check(name, {24'd0, dbg_data}, {24'd0, model[a]});
  endtask

  task automatic check_idle(input string name);
    @(negedge sclk);
    #1;
    check(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    ss       = 1'b1;
    in       = 1'b0;
    dbg_addr = 3'd0;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(negedge sclk);
    check("reset_out", {31'd0, out}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_wr_done", {31'd0, wr_done}, 32'd0);
    check("reset_rd_done", {31'd0, rd_done}, 32'd0);
    check("reset_rx_addr", {29'd0, rx_addr}, 32'd0);
    for (int a = 0; a < 8; a++) check_dbg("reset_dbg", 3'(a));
    rst = 1'b0;

    // Write then read back
    frame(8'h03, 8'hA5);
    check_idle("busy_after_write");
    for (int a = 0; a < 8; a++) check_dbg("write_dbg", 3'(a));
    frame(8'h83, 8'h00);
    check_dbg("readback_keeps_mem", 3'd3);

    // Abort after 4 data bits
    send_bits(24'h05FF >> 4, 12);
    idle(1);
    check_idle("busy_after_abort");
    check_dbg("abort_no_write", 3'd5);

    // ss rises exactly on edge 16: abort
    send_bits(24'h065A >> 1, 15);
    idle(1);
    check_idle("busy_after_edge16_abort");
    check_dbg("edge16_abort_no_write", 3'd6);

    // Overrun: 24 bits with ss low, then a read
    begin
      exp_t e;
      e.is_read = 1'b0;
      e.addr    = 3'd2;
      e.data    = 8'h3C;
      expq.push_back(e);
      model[2] = 8'h3C;
    end
    send_bits(24'h023CFF, 24);
    idle(1);
    check_dbg("overrun_write", 3'd2);
    frame(8'h82, 8'h00);

    // Reset at edge 12 of a write of 0x77 to address 1
    send_bits(24'h0177 >> 5, 11);
    @(negedge sclk);
    rst = 1'b1;
    ss  = 1'b0;
    in  = 1'b1;
    @(negedge sclk);
    rst = 1'b0;
    ss  = 1'b1;
    #1;
    check("busy_after_midframe_rst", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    check_dbg("midframe_rst_no_write", 3'd1);
    frame(8'h01, 8'h77);
    check_dbg("write_after_rst", 3'd1);
    frame(8'h81, 8'h00);

    // Randomized frames, reads, writes and aborts
    for (int k = 0; k < 80; k++) begin
      bit [7:0]  cmd;
      bit [7:0]  data;
      bit [15:0] f;
      int        n;
      cmd  = 8'($urandom);
      data = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        f = {cmd, data};
        n = $urandom_range(1, 15);
        send_bits({8'h00, f} >> (16 - n), n);
        idle(1);
        check_idle("busy_after_rand_abort");
      end else begin
        frame(cmd, data);
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
    end

    idle(3);
    check("queue_drained", expq.size(), 32'd0);
    for (int a = 0; a < 8; a++) check_dbg("final_dbg", 3'(a));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
